// File: rtl/tour_pkg.sv
// Shared constants and types for the knight's-tour sequencer and TourCmd.
package tour_pkg;

    // Opcode in cmd[15:12] that requests a tour
    localparam logic [3:0] OP_TOUR        = 4'h4;

    // 24 moves, each issued as a Y half-move followed by an X half-move
    localparam logic [5:0] LAST_HALF_MOVE = 6'd47;

    // Largest legal start coordinate on the 5x5 board
    localparam logic [2:0] BOARD_MAX      = 3'd4;

    // TourCmd move indexing
    localparam int unsigned NUM_MOVES     = 24;
    localparam int unsigned MOVE_IDX_W    = 5;
    localparam logic [4:0]  LAST_MOVE_IDX = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SOLVE,
        HANDOFF,
        TOURING
    } tour_state_t;

    // True when both coordinates fall on the board
    function automatic logic on_board(input logic [2:0] x, input logic [2:0] y);
        return (x <= BOARD_MAX) && (y <= BOARD_MAX);
    endfunction

endpackage

// File: rtl/tour_wdog.sv
// Solve watchdog: free-running counter with synchronous clear and enable,
// flagging when it reaches all-ones.
module tour_wdog #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = &cnt_q;

endmodule

// File: rtl/tour_ctrl.sv
// Knight's-tour sequencer: intercepts tour commands from the UART wrapper,
// launches TourLogic, waits for a solution, hands off to TourCmd and counts
// the 48 half-move acknowledgements to completion.
// Build option: define TOUR_TIMEOUT_EN to include the SOLVE watchdog
// (tour_wdog); without it SOLVE waits on tour_done indefinitely.
module tour_ctrl
    import tour_pkg::*;
#(
    parameter int TIMEOUT_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        cmd_rdy_fwd,
    output logic        clr_tour_cmd,
    output logic        tour_go,
    output logic [2:0]  x_start,
    output logic [2:0]  y_start,
    input  logic        tour_done,
    output logic        start_tour,
    input  logic        send_resp,
    output logic        tour_busy,
    output logic        tour_cmplt,
    output logic        tour_err
);

    tour_state_t state_q, state_d;
    logic [2:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        go_q, go_d;
    logic        start_q, start_d;
    logic [5:0]  hm_cnt_q, hm_cnt_d;

    logic        is_tour_op;
    logic        tour_req;
    logic [2:0]  req_x;
    logic [2:0]  req_y;
    logic        wd_expired;
    logic        unused_cmd_bits;

    assign is_tour_op = (cmd_UART[15:12] == OP_TOUR);
    assign tour_req   = cmd_rdy_UART & is_tour_op;
    assign req_x      = cmd_UART[6:4];
    assign req_y      = cmd_UART[2:0];

    // Remaining command fields belong to cmd_proc, not to this block
    assign unused_cmd_bits = ^{cmd_UART[11:7], cmd_UART[3]};

    // Tour commands never reach TourCmd; every other command passes through
    assign cmd_rdy_fwd  = cmd_rdy_UART & ~is_tour_op;
    // Any tour command is consumed at the wrapper, accepted or not
    assign clr_tour_cmd = tour_req;

`ifdef TOUR_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    assign wd_clr = (state_q == LAUNCH);
    assign wd_en  = (state_q == SOLVE);

    tour_wdog #(
        .W (TIMEOUT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    // No watchdog: SOLVE never times out and the width has no consumer
    localparam int unused_timeout_w = TIMEOUT_W;
    assign wd_expired = 1'b0;
`endif

    // Next-state, registered-output and completion decode
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        err_d      = err_q;
        go_d       = 1'b0;
        start_d    = 1'b0;
        hm_cnt_d   = hm_cnt_q;
        tour_cmplt = 1'b0;

        case (state_q)
            IDLE: begin
                if (tour_req) begin
                    x_d = req_x;
                    y_d = req_y;
                    if (!on_board(req_x, req_y)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        go_d    = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_d = SOLVE;
            end
            SOLVE: begin
                // A solution arriving on the timeout cycle still counts
                if (tour_done) begin
                    start_d = 1'b1;
                    state_d = HANDOFF;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            HANDOFF: begin
                hm_cnt_d = '0;
                state_d  = TOURING;
            end
            TOURING: begin
                if (send_resp) begin
                    if (hm_cnt_q == LAST_HALF_MOVE) begin
                        tour_cmplt = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        hm_cnt_d = hm_cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tour request while busy is dropped but flagged
        if (tour_req && (state_q != IDLE))
            err_d = 1'b1;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            go_q     <= 1'b0;
            start_q  <= 1'b0;
            hm_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            go_q     <= go_d;
            start_q  <= start_d;
            hm_cnt_q <= hm_cnt_d;
        end
    end

    assign tour_go    = go_q;
    assign start_tour = start_q;
    assign x_start    = x_q;
    assign y_start    = y_q;
    assign tour_busy  = busy_q;
    assign tour_err   = err_q;

endmodule

// File: tb/tb_tour_ctrl.sv
// Bench for tour_ctrl: directed command/solve/response sequences with a
// timestamp-based reference model checked every cycle, plus literal checks.
module tb_tour_ctrl;

    localparam int WD_W = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        cmd_rdy_fwd;
    logic        clr_tour_cmd;
    logic        tour_go;
    logic [2:0]  x_start;
    logic [2:0]  y_start;
    logic        tour_done;
    logic        start_tour;
    logic        send_resp;
    logic        tour_busy;
    logic        tour_cmplt;
    logic        tour_err;

    int n_cmp  = 0;
    int n_fail = 0;

    tour_ctrl #(.TIMEOUT_W(WD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd_rdy_fwd  (cmd_rdy_fwd),
        .clr_tour_cmd (clr_tour_cmd),
        .tour_go      (tour_go),
        .x_start      (x_start),
        .y_start      (y_start),
        .tour_done    (tour_done),
        .start_tour   (start_tour),
        .send_resp    (send_resp),
        .tour_busy    (tour_busy),
        .tour_cmplt   (tour_cmplt),
        .tour_err     (tour_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a tour is described by its accept cycle, the cycle
    // its solution was seen and the number of responses so far.
    int         cyc      = 0;
    int         acc_cyc  = -100;
    int         done_cyc = -1;
    int         n_resp   = 0;
    bit         m_active = 0;
    bit         m_err    = 0;
    logic [2:0] m_x      = 0;
    logic [2:0] m_y      = 0;

    always @(posedge clk) begin
        bit was_active;
        bit solving;
        bit touring;
        bit req;
        if (!rst_n) begin
            acc_cyc  = -100;
            done_cyc = -1;
            n_resp   = 0;
            m_active = 0;
            m_err    = 0;
            m_x      = 0;
            m_y      = 0;
        end else begin
            was_active = m_active;
            solving = m_active && (cyc >= acc_cyc + 2) && (done_cyc < 0);
            touring = m_active && (done_cyc >= 0) && (cyc >= done_cyc + 2);
            req     = cmd_rdy_UART && (cmd_UART[15:12] == 4'h4);
            if (touring && send_resp) begin
                n_resp++;
                if (n_resp == 48)
                    m_active = 0;
            end
            if (solving && tour_done)
                done_cyc = cyc;
`ifdef TOUR_TIMEOUT_EN
            else if (solving && (cyc - (acc_cyc + 2)) == (1 << WD_W) - 1) begin
                m_active = 0;
                m_err    = 1;
            end
`endif
            if (req) begin
                if (!was_active) begin
                    m_x = cmd_UART[6:4];
                    m_y = cmd_UART[2:0];
                    if (cmd_UART[6:4] > 3'd4 || cmd_UART[2:0] > 3'd4) begin
                        m_err = 1;
                    end else begin
                        m_err    = 0;
                        m_active = 1;
                        acc_cyc  = cyc;
                        done_cyc = -1;
                        n_resp   = 0;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
        cyc++;
    end

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        logic e_fwd, e_clr, e_go, e_start, e_cmplt, e_busy, e_err;
        logic [2:0] e_x, e_y;
        bit touring;
        e_fwd = cmd_rdy_UART && (cmd_UART[15:12] != 4'h4);
        e_clr = cmd_rdy_UART && (cmd_UART[15:12] == 4'h4);
        if (!rst_n) begin
            e_go = 0; e_start = 0; e_cmplt = 0; e_busy = 0; e_err = 0;
            e_x = 0; e_y = 0;
        end else begin
            touring = m_active && (done_cyc >= 0) && (cyc >= done_cyc + 2);
            e_go    = m_active && (cyc == acc_cyc + 1);
            e_start = m_active && (done_cyc >= 0) && (cyc == done_cyc + 1);
            e_cmplt = touring && send_resp && (n_resp == 47);
            e_busy  = m_active;
            e_err   = m_err;
            e_x     = m_x;
            e_y     = m_y;
        end
        chk("m_fwd",   {7'd0, cmd_rdy_fwd},  {7'd0, e_fwd});
        chk("m_clr",   {7'd0, clr_tour_cmd}, {7'd0, e_clr});
        chk("m_go",    {7'd0, tour_go},      {7'd0, e_go});
        chk("m_start", {7'd0, start_tour},   {7'd0, e_start});
        chk("m_cmplt", {7'd0, tour_cmplt},   {7'd0, e_cmplt});
        chk("m_busy",  {7'd0, tour_busy},    {7'd0, e_busy});
        chk("m_err",   {7'd0, tour_err},     {7'd0, e_err});
        chk("m_x",     {5'd0, x_start},      {5'd0, e_x});
        chk("m_y",     {5'd0, y_start},      {5'd0, e_y});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic req(input logic [15:0] c);
        cmd_UART     = c;
        cmd_rdy_UART = 1'b1;
    endtask

    // Issue n responses spaced by one idle cycle
    task automatic responses(input int n);
        for (int i = 0; i < n; i++) begin
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        tour_done    = 1'b0;
        send_resp    = 1'b0;

        tick(); tick(); neg();
        chk("rst_busy", {7'd0, tour_busy}, 8'd0);
        chk("rst_err",  {7'd0, tour_err},  8'd0);
        chk("rst_go",   {7'd0, tour_go},   8'd0);
        chk("rst_x",    {5'd0, x_start},   8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Accepted tour from (2,2), solution 100 cycles after tour_go
        req(16'h4022); neg();
        chk("t1_clr",      {7'd0, clr_tour_cmd}, 8'd1);
        chk("t1_fwd",      {7'd0, cmd_rdy_fwd},  8'd0);
        chk("t1_go_early", {7'd0, tour_go},      8'd0);
        tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("t1_go",   {7'd0, tour_go},   8'd1);
        chk("t1_x",    {5'd0, x_start},   8'd2);
        chk("t1_y",    {5'd0, y_start},   8'd2);
        chk("t1_busy", {7'd0, tour_busy}, 8'd1);
        repeat (100) tick();
        tour_done = 1'b1; neg();
        chk("t1_start_early", {7'd0, start_tour}, 8'd0);
        tick();
        tour_done = 1'b0; neg();
        chk("t1_start", {7'd0, start_tour}, 8'd1);
        tick();
        for (int i = 0; i < 48; i++) begin
            send_resp = 1'b1; neg();
            if (i == 47)
                chk("t1_cmplt", {7'd0, tour_cmplt}, 8'd1);
            else if (i == 0)
                chk("t1_cmplt_early", {7'd0, tour_cmplt}, 8'd0);
            tick();
            send_resp = 1'b0;
            if (i == 47) begin
                neg();
                chk("t1_busy_end", {7'd0, tour_busy}, 8'd0);
                chk("t1_err_end",  {7'd0, tour_err},  8'd0);
            end
            tick();
        end

        // Off-board start square x=5
        req(16'h4050); neg();
        chk("bad_clr", {7'd0, clr_tour_cmd}, 8'd1);
        tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("bad_err",  {7'd0, tour_err},  8'd1);
        chk("bad_busy", {7'd0, tour_busy}, 8'd0);
        chk("bad_go",   {7'd0, tour_go},   8'd0);
        tick(); tick();

        // Tour from (1,3) with a rejected request at half-move 10
        req(16'h4013); tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("t3_err_clr", {7'd0, tour_err}, 8'd0);
        repeat (5) tick();
        tour_done = 1'b1; tick();
        tour_done = 1'b0; tick();
        responses(10);
        req(16'h4044); neg();
        chk("rej_clr", {7'd0, clr_tour_cmd}, 8'd1);
        tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("rej_err",  {7'd0, tour_err},  8'd1);
        chk("rej_x",    {5'd0, x_start},   8'd1);
        chk("rej_y",    {5'd0, y_start},   8'd3);
        chk("rej_busy", {7'd0, tour_busy}, 8'd1);
        tick();
        responses(37);
        send_resp = 1'b1; neg();
        chk("t3_cmplt", {7'd0, tour_cmplt}, 8'd1);
        tick();
        send_resp = 1'b0; neg();
        chk("t3_busy_end", {7'd0, tour_busy}, 8'd0);
        chk("t3_err_kept", {7'd0, tour_err},  8'd1);
        tick();

        // Solve with no solution
        req(16'h4000); tick();
        cmd_rdy_UART = 1'b0;
        repeat (300) tick();
        neg();
`ifdef TOUR_TIMEOUT_EN
        chk("to_err",  {7'd0, tour_err},  8'd1);
        chk("to_busy", {7'd0, tour_busy}, 8'd0);
        tick();
        req(16'h4000); tick();
        cmd_rdy_UART = 1'b0;
        repeat (3) tick();
`else
        chk("noto_busy", {7'd0, tour_busy}, 8'd1);
        chk("noto_err",  {7'd0, tour_err},  8'd0);
        tick();
`endif
        tour_done = 1'b1; tick();
        tour_done = 1'b0; tick();

        // Reset at half-move 30 with a non-tour command present
        responses(30);
        rst_n = 1'b0;
        req(16'h2012); neg();
        chk("rst2_fwd",   {7'd0, cmd_rdy_fwd},  8'd1);
        chk("rst2_clr",   {7'd0, clr_tour_cmd}, 8'd0);
        chk("rst2_busy",  {7'd0, tour_busy},    8'd0);
        chk("rst2_err",   {7'd0, tour_err},     8'd0);
        chk("rst2_go",    {7'd0, tour_go},      8'd0);
        chk("rst2_start", {7'd0, start_tour},   8'd0);
        chk("rst2_cmplt", {7'd0, tour_cmplt},   8'd0);
        chk("rst2_x",     {5'd0, x_start},      8'd0);
        tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("rst2_fwd_low", {7'd0, cmd_rdy_fwd}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        req(16'h2012); neg();
        chk("pass_fwd", {7'd0, cmd_rdy_fwd},  8'd1);
        chk("pass_clr", {7'd0, clr_tour_cmd}, 8'd0);
        tick();
        cmd_rdy_UART = 1'b0; neg();
        chk("pass_busy", {7'd0, tour_busy}, 8'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tour_ctrl.md
# tour_ctrl

Sequencer for the knight's-tour flow. Intercepts "start tour" commands from the UART wrapper, launches TourLogic with the requested start square, and waits for a solution. It then hands the command path to TourCmd and counts the 48 half-moves to completion. Sits between UART_wrapper, TourLogic, TourCmd and cmd_proc.

## Interface
- TIMEOUT_W, 26: width of the solve watchdog counter. Timeout fires at all-ones, 2^26-1 cycles.
- OP_TOUR, 4'h4: opcode in cmd_UART[15:12] that requests a tour.
- clk  in  1  50MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_UART  in  16  command from UART_wrapper; [6:4] start x, [2:0] start y
- cmd_rdy_UART  in  1  command valid from UART_wrapper
- cmd_rdy_fwd  out  1  cmd_rdy toward TourCmd, with tour commands masked off
- clr_tour_cmd  out  1  one-cycle pulse; consumes a tour command at UART_wrapper
- tour_go  out  1  one-cycle pulse; starts TourLogic
- x_start  out  3  registered start column for TourLogic
- y_start  out  3  registered start row for TourLogic
- tour_done  in  1  TourLogic solution ready
- start_tour  out  1  one-cycle pulse to TourCmd
- send_resp  in  1  cmd_proc finished one move command
- tour_busy  out  1  high from command accept until completion or error
- tour_cmplt  out  1  one-cycle pulse when the final half-move is acknowledged
- tour_err  out  1  sticky; set by a bad start square, a busy reject or a timeout; cleared by the next accepted tour command

## Operation
- tour_req = cmd_rdy_UART & (cmd_UART[15:12] == OP_TOUR).
- cmd_rdy_fwd = cmd_rdy_UART & ~(cmd_UART[15:12] == OP_TOUR), in every state.
- States: IDLE, LAUNCH, SOLVE, HANDOFF, TOURING.
- IDLE
  - On tour_req: pulse clr_tour_cmd and capture x_start/y_start.
  - If x > 4 or y > 4: set tour_err and stay in IDLE.
  - Otherwise: clear tour_err, set tour_busy, go to LAUNCH.
- LAUNCH: assert tour_go for one cycle, clear the watchdog, go to SOLVE.
- SOLVE
  - Watchdog increments every cycle.
  - On tour_done: go to HANDOFF.
  - On watchdog all-ones without tour_done: set tour_err, clear tour_busy, go to IDLE.
  - If tour_done and timeout land in the same cycle, tour_done wins.
- HANDOFF: assert start_tour for one cycle, clear the 6-bit half-move counter hm_cnt, go to TOURING.
- TOURING
  - Each send_resp increments hm_cnt.
  - On send_resp with hm_cnt == 47: pulse tour_cmplt, clear tour_busy, go to IDLE.
- tour_req outside IDLE: still pulses clr_tour_cmd and is dropped. tour_err is set, and the state, x_start/y_start and counters are unchanged.
- send_resp outside TOURING is ignored.

## Timing
- Reset values: every output and internal register is 0; state = IDLE.
- Reset asserted mid-tour returns to IDLE at once, with no tour_cmplt.
- tour_req in cycle N: clr_tour_cmd in N. tour_go in N+1 and N+2 is SOLVE.
- tour_done sampled in cycle M: start_tour in M+1, TOURING from M+2.
- hm_cnt counts 0..47, 48 responses in total (24 moves × Y and X). It never wraps because the FSM leaves TOURING at 47.
- tour_cmplt is in the same cycle as the 48th send_resp. tour_busy is low the next cycle.
- Every pulse output is exactly one cycle, registered or decoded from the current state. There are no combinational paths from inputs to tour_go or start_tour.

## Configuration
- TOUR_TIMEOUT_EN defined: the SOLVE watchdog is built as described.
- TOUR_TIMEOUT_EN undefined:
  - The watchdog counter is not instantiated.
  - SOLVE waits on tour_done indefinitely.
  - tour_err can be set only by a bad start square or a busy reject.
  - TIMEOUT_W is unused.

## Structure
- Shared package tour_pkg holds:
  - OP_TOUR
  - the state enum tour_state_t
  - LAST_HALF_MOVE = 6'd47
  - BOARD_MAX = 3'd4
- TourCmd's move-index constants move into the same package.
- One sub-module, tour_wdog: a counter with clear, enable and an all-ones flag. It is instantiated only under TOUR_TIMEOUT_EN.

## Test plan
- cmd_UART=16'h4022 with cmd_rdy_UART → clr_tour_cmd in the same cycle, tour_go the next cycle, x_start=2, y_start=2, cmd_rdy_fwd=0, tour_busy=1.
- Full run:
  - tour_done 100 cycles after tour_go → start_tour one cycle later.
  - Drive 48 send_resp pulses → tour_cmplt on the 48th, tour_busy=0, tour_err=0.
- cmd_UART=16'h4050 (x=5) → clr_tour_cmd, tour_err=1, no tour_go, tour_busy stays 0.
- Second tour_req during TOURING at hm_cnt=10 → clr_tour_cmd, tour_err=1, hm_cnt and x_start unchanged, tour completes normally.
- With TOUR_TIMEOUT_EN and TIMEOUT_W=8, no tour_done → tour_err=1 and IDLE 255 cycles after SOLVE entry. Without the macro → remains in SOLVE.
- rst_n low at hm_cnt=30, and cmd_UART=16'h2012 forwarded → all outputs 0. Non-tour command passes through with cmd_rdy_fwd=cmd_rdy_UART.
